// File: rtl/ptw_refill_ctrl.sv
// Sv32 page-table walker and TLB refill controller with round-robin I/D miss arbitration.
// Define PTW_SUPERPAGE_EN to accept level-1 leaves as 4 MiB superpages; otherwise they fault.
module ptw_refill_ctrl #(
    parameter  int TLB_ENTRIES = 16,
    localparam int IW          = $clog2(TLB_ENTRIES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [31:0]   satp,
    input  logic          i_req,
    input  logic [31:0]   i_vaddr,
    input  logic          d_req,
    input  logic [31:0]   d_vaddr,
    input  logic          d_is_store,
    output logic          mem_req,
    output logic [31:0]   mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          tlb_we,
    output logic [31:0]   tlb_vpn,
    output logic [31:0]   tlb_ppn_perms,
    output logic [IW-1:0] tlb_index,
    output logic          i_done,
    output logic          d_done,
    output logic          fault,
    output logic [4:0]    fault_cause
);
    typedef enum logic [1:0] {S_IDLE, S_WALK1, S_WALK0, S_RESP} state_t;

    state_t        r_state;
    logic          r_i_pend, r_d_pend, r_last_i, r_side_i, r_is_store;
    logic [19:0]   r_vpn;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic          r_tlb_we;
    logic [31:0]   r_tlb_vpn, r_tlb_ppn_perms;
    logic [IW-1:0] r_tlb_index;
    logic          r_i_done, r_d_done, r_fault;
    logic [4:0]    r_fault_cause;

    logic          w_grant_d, w_grant_i;
    logic [19:0]   w_va_sel;
    logic          w_pte_invalid, w_pte_leaf, w_perm_ok, w_leaf_ok;
    logic [4:0]    w_cause;
    logic          w_finish, w_ok;
    logic [19:0]   w_ppn;
    logic          w_unused;

    // D wins a tie unless it was granted last.
    assign w_grant_d = r_d_pend & (~r_i_pend | r_last_i);
    assign w_grant_i = r_i_pend & ~w_grant_d;
    assign w_va_sel  = w_grant_d ? d_vaddr[31:12] : i_vaddr[31:12];

    assign w_pte_invalid = ~mem_rdata[0] | (~mem_rdata[1] & mem_rdata[2]) | (|mem_rdata[31:30]);
    assign w_pte_leaf    = mem_rdata[1] | mem_rdata[3];
    assign w_perm_ok     = r_side_i ? mem_rdata[3] : (r_is_store ? mem_rdata[2] : mem_rdata[1]);
    assign w_leaf_ok     = w_perm_ok & mem_rdata[6] & (~r_is_store | mem_rdata[7]);
    assign w_cause       = r_side_i ? 5'd12 : (r_is_store ? 5'd15 : 5'd13);

    assign w_unused = ^{satp[30:20], i_vaddr[11:0], d_vaddr[11:0], mem_rdata[9:8]};

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        w_finish = 1'b0;
        w_ok     = 1'b0;
        w_ppn    = mem_rdata[29:10];
        if (r_state == S_WALK1 && mem_ack) begin
            w_finish = w_pte_invalid | w_pte_leaf;
`ifdef PTW_SUPERPAGE_EN
            w_ok  = ~w_pte_invalid & w_pte_leaf & w_leaf_ok & (mem_rdata[19:10] == 10'd0);
            w_ppn = {mem_rdata[29:20], r_vpn[9:0]};
`endif
        end else if (r_state == S_WALK0 && mem_ack) begin
            w_finish = 1'b1;
            w_ok     = ~w_pte_invalid & w_pte_leaf & w_leaf_ok;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the later write in RESP wins over capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_i_pend        <= 1'b0;
            r_d_pend        <= 1'b0;
            r_last_i        <= 1'b1;
            r_side_i        <= 1'b0;
            r_is_store      <= 1'b0;
            r_vpn           <= '0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= '0;
            r_tlb_we        <= 1'b0;
            r_tlb_vpn       <= '0;
            r_tlb_ppn_perms <= '0;
            r_tlb_index     <= '0;
            r_i_done        <= 1'b0;
            r_d_done        <= 1'b0;
            r_fault         <= 1'b0;
            r_fault_cause   <= '0;
        end else begin
            if (i_req && !r_i_pend) r_i_pend <= 1'b1;
            if (d_req && !r_d_pend) r_d_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (r_i_pend || r_d_pend) begin
                        r_side_i   <= w_grant_i;
                        r_last_i   <= w_grant_i;
                        r_is_store <= w_grant_d & d_is_store;
                        r_vpn      <= w_va_sel;
                        if (satp[31]) begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {satp[19:0], w_va_sel[19:10], 2'b00};
                            r_state    <= S_WALK1;
                        end else begin
                            r_i_done <= w_grant_i;
                            r_d_done <= w_grant_d;
                            r_state  <= S_RESP;
                        end
                    end
                end
                S_WALK1, S_WALK0: begin
                    if (w_finish) begin
                        r_mem_req       <= 1'b0;
                        r_i_done        <= r_side_i;
                        r_d_done        <= ~r_side_i;
                        r_fault         <= ~w_ok;
                        r_fault_cause   <= w_ok ? 5'd0 : w_cause;
                        r_tlb_we        <= w_ok;
                        r_tlb_vpn       <= w_ok ? {12'b0, r_vpn} : 32'd0;
                        r_tlb_ppn_perms <= w_ok ? {w_ppn, 4'b0, mem_rdata[7:0]} : 32'd0;
                        r_state         <= S_RESP;
                    end else if (mem_ack) begin
                        // Only a level-1 pointer reaches here; mem_req stays high across levels.
                        r_mem_addr <= {mem_rdata[29:10], r_vpn[9:0], 2'b00};
                        r_state    <= S_WALK0;
                    end
                end
                S_RESP: begin
                    if (r_side_i) r_i_pend <= 1'b0;
                    else          r_d_pend <= 1'b0;
                    if (r_tlb_we) r_tlb_index <= r_tlb_index + IW'(1);
                    r_i_done        <= 1'b0;
                    r_d_done        <= 1'b0;
                    r_fault         <= 1'b0;
                    r_fault_cause   <= '0;
                    r_tlb_we        <= 1'b0;
                    r_tlb_vpn       <= '0;
                    r_tlb_ppn_perms <= '0;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req       = r_mem_req;
    assign mem_addr      = r_mem_addr;
    assign tlb_we        = r_tlb_we;
    assign tlb_vpn       = r_tlb_vpn;
    assign tlb_ppn_perms = r_tlb_ppn_perms;
    assign tlb_index     = r_tlb_index;
    assign i_done        = r_i_done;
    assign d_done        = r_d_done;
    assign fault         = r_fault;
    assign fault_cause   = r_fault_cause;
endmodule

// File: tb/tb_ptw_refill_ctrl.sv
// Scoreboard bench for ptw_refill_ctrl: stimulus pushes expected responses, a monitor pops them on done.
// Expectations for level-1 leaves follow PTW_SUPERPAGE_EN.
module tb_ptw_refill_ctrl;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   satp;
    logic          i_req, d_req, d_is_store;
    logic [31:0]   i_vaddr, d_vaddr;
    logic          mem_req, mem_ack;
    logic [31:0]   mem_addr, mem_rdata;
    logic          tlb_we;
    logic [31:0]   tlb_vpn, tlb_ppn_perms;
    logic [IW-1:0] tlb_index;
    logic          i_done, d_done, fault;
    logic [4:0]    fault_cause;

    ptw_refill_ctrl #(.TLB_ENTRIES(16)) dut (
        .clk(clk), .reset_n(reset_n), .satp(satp),
        .i_req(i_req), .i_vaddr(i_vaddr),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_is_store(d_is_store),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .tlb_we(tlb_we), .tlb_vpn(tlb_vpn), .tlb_ppn_perms(tlb_ppn_perms), .tlb_index(tlb_index),
        .i_done(i_done), .d_done(d_done), .fault(fault), .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          side_d;
        logic          fault;
        logic [4:0]    cause;
        logic          we;
        logic [31:0]   vpn;
        logic [31:0]   ppn;
        logic [IW-1:0] idx;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [IW-1:0] exp_idx = '0;
    logic [31:0]   mem [logic [31:0]];
    logic [31:0]   hold_addr = 32'hFFFF_FFFF;
    int            mem_wait = 0;
    int            wait_cnt = 0;
    int            mem_accesses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: acks after mem_wait idle cycles, never for hold_addr.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_req && mem_addr != hold_addr && wait_cnt >= mem_wait) begin
                check("mem_addr_mapped", 32'(mem.exists(mem_addr)), 32'd1);
                mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                mem_ack   = 1'b1;
                mem_accesses++;
                wait_cnt  = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = (reset_n && mem_req) ? wait_cnt + 1 : 0;
            end
        end
    end

    // Monitor: pops one expected response per done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (tlb_we && !(i_done || d_done))
                    check("tlb_we_without_done", 32'(tlb_we), 32'd0);
                if (i_done || d_done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual i_done=%b d_done=%b required none (cycle %0d)",
                                 i_done, d_done, cyc);
                    end else begin
                        mon_e = sb.pop_front();
                        check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                        check("i_done", 32'(i_done), 32'(!mon_e.side_d));
                        check("d_done", 32'(d_done), 32'(mon_e.side_d));
                        check("fault", 32'(fault), 32'(mon_e.fault));
                        check("fault_cause", 32'(fault_cause), 32'(mon_e.cause));
                        check("tlb_we", 32'(tlb_we), 32'(mon_e.we));
                        check("tlb_index", 32'(tlb_index), 32'(mon_e.idx));
                        if (mon_e.we) begin
                            check("tlb_vpn", tlb_vpn, mon_e.vpn);
                            check("tlb_ppn_perms", tlb_ppn_perms, mon_e.ppn);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic pulse(input logic pi, input logic pd, output int n);
        @(posedge clk);
        #1;
        i_req = pi;
        d_req = pd;
        n     = cyc;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic expect_resp(input logic side_d, input logic flt, input logic [4:0] cause,
                               input logic we, input logic [31:0] vpn, input logic [31:0] ppn,
                               input int at);
        exp_t e;
        e.side_d = side_d;
        e.fault  = flt;
        e.cause  = cause;
        e.we     = we;
        e.vpn    = vpn;
        e.ppn    = ppn;
        e.idx    = exp_idx;
        e.cyc    = at;
        sb.push_back(e);
        if (we) exp_idx = exp_idx + 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual outstanding=%0d required 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_idx = '0;
    endtask

    initial begin
        int n;
        int acc0;
        int k;
        reset_n    = 1'b0;
        satp       = '0;
        i_req      = 1'b0;
        d_req      = 1'b0;
        d_is_store = 1'b0;
        i_vaddr    = '0;
        d_vaddr    = '0;
        mem[32'h0010_0004] = 32'h0008_0001;
        mem[32'h0020_000C] = 32'h0123_40C7;
        mem[32'h0010_000C] = 32'h0000_0000;
        mem[32'h0020_0014] = 32'h0000_004F;
        mem[32'h0020_0004] = 32'h2000_00CF;
        mem[32'h0020_0018] = 32'h0ABC_D04B;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_tlb_we", 32'(tlb_we), 32'd0);
        check("rst_tlb_vpn", tlb_vpn, 32'd0);
        check("rst_tlb_ppn_perms", tlb_ppn_perms, 32'd0);
        check("rst_tlb_index", 32'(tlb_index), 32'd0);
        check("rst_i_done", 32'(i_done), 32'd0);
        check("rst_d_done", 32'(d_done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_cause", 32'(fault_cause), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Two-level D load walk.
        satp    = 32'h8000_0100;
        d_vaddr = 32'h0040_3ABC;
        pulse(1'b0, 1'b1, n);
        expect_resp(1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0403, 32'h048D_00C7, n + 4);
        wait_idle("d_load");

        // I fetch hitting an invalid level-1 PTE.
        i_vaddr = 32'h00C0_1000;
        acc0    = mem_accesses;
        pulse(1'b1, 1'b0, n);
        expect_resp(1'b0, 1'b1, 5'd12, 1'b0, 32'd0, 32'd0, n + 3);
        wait_idle("i_fault");
        check("i_fault_mem_accesses", 32'(mem_accesses - acc0), 32'd1);

        // D store to a clean page, one wait cycle per level.
        d_vaddr    = 32'h0040_5000;
        d_is_store = 1'b1;
        mem_wait   = 1;
        pulse(1'b0, 1'b1, n);
        expect_resp(1'b1, 1'b1, 5'd15, 1'b0, 32'd0, 32'd0, n + 6);
        wait_idle("store_fault");
        mem_wait   = 0;
        d_is_store = 1'b0;
        check("store_fault_index", 32'(tlb_index), 32'(exp_idx));

        // Level-1 leaf.
        satp    = 32'h8000_0200;
        d_vaddr = 32'h0040_3ABC;
        pulse(1'b0, 1'b1, n);
`ifdef PTW_SUPERPAGE_EN
        expect_resp(1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0403, 32'h8000_30CF, n + 3);
`else
        expect_resp(1'b1, 1'b1, 5'd13, 1'b0, 32'd0, 32'd0, n + 3);
`endif
        wait_idle("superpage");

        // Bare mode: no walk, no refill.
        satp = 32'h0000_0000;
        acc0 = mem_accesses;
        pulse(1'b0, 1'b1, n);
        expect_resp(1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, n + 2);
        wait_idle("bare");
        check("bare_mem_accesses", 32'(mem_accesses - acc0), 32'd0);

        // Asynchronous reset during WALK0 with the ack withheld.
        satp      = 32'h8000_0100;
        hold_addr = 32'h0020_000C;
        pulse(1'b0, 1'b1, n);
        k = 0;
        while (!(mem_req && mem_addr == 32'h0020_000C) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("walk0_mem_req", 32'(mem_req), 32'd1);
        check("walk0_mem_addr", mem_addr, 32'h0020_000C);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_mem_req_drop", 32'(mem_req), 32'd0);
        check("async_tlb_index", 32'(tlb_index), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_no_d_done", 32'(d_done), 32'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        hold_addr = 32'hFFFF_FFFF;
        exp_idx   = '0;
        repeat (4) @(posedge clk);
        #1;
        check("no_walk_after_reset", 32'(mem_req), 32'd0);

        pulse(1'b0, 1'b1, n);
        expect_resp(1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0403, 32'h048D_00C7, n + 4);
        wait_idle("walk_after_reset");

        // Simultaneous requests after reset: D first, then I back-to-back.
        do_reset();
        i_vaddr = 32'h0040_6000;
        pulse(1'b1, 1'b1, n);
        expect_resp(1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0403, 32'h048D_00C7, n + 4);
        expect_resp(1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0406, 32'h2AF3_404B, n + 8);
        wait_idle("tie");

        // Refills 3..17; the 17th lands in slot 0 again.
        for (int r = 2; r < 17; r++) begin
            pulse(1'b0, 1'b1, n);
            expect_resp(1'b1, 1'b0, 5'd0, 1'b1, 32'h0000_0403, 32'h048D_00C7, n + 4);
            wait_idle("wrap");
        end
        check("index_after_wrap", 32'(tlb_index), 32'd1);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
